// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared op/state encodings and sizing helpers for the memory-access stage
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_LWU  = 4'd6,
    OP_LD   = 4'd7,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10,
    OP_SD   = 4'd11
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } mau_state_t;

  localparam logic EXC_ADEL = 1'b0;
  localparam logic EXC_ADES = 1'b1;

  function automatic int bytes_of(int dw);
    return dw / 8;
  endfunction

  function automatic int off_width(int dw);
    return $clog2(dw / 8);
  endfunction

  // Access size in bytes; 0 marks a non-memory op.
  function automatic logic [3:0] op_size(mem_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB:  return 4'd1;
      OP_LH, OP_LHU, OP_SH:  return 4'd2;
      OP_LW, OP_LWU, OP_SW:  return 4'd4;
      OP_LD, OP_SD:          return 4'd8;
      default:               return 4'd0;
    endcase
  endfunction

  function automatic logic op_is_store(mem_op_t op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic logic op_is_signed(mem_op_t op);
    return op inside {OP_LB, OP_LH, OP_LW};
  endfunction

endpackage

// File: rtl/mem_lane_format.sv
// rtl/mem_lane_format.sv - big-endian byte-lane steering, extension and alignment check
module mem_lane_format
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int OFFW  = $clog2(DATA_WIDTH / 8)
) (
  input  mem_op_t               op,
  input  logic [OFFW-1:0]       offset,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [BYTES-1:0]      strb,
  output logic [DATA_WIDTH-1:0] wdata_rep,
  output logic [DATA_WIDTH-1:0] rdata_ext,
  output logic                  misalign
);

  logic [3:0]            size;
  logic [2:0]            off3;
  logic                  sgn;
  int                    lo;
  int                    shamt;
  logic [DATA_WIDTH-1:0] shifted;

  assign size = op_size(op);
  assign off3 = 3'(offset);
  assign sgn  = op_is_signed(op);

  // Lowest bus lane of the field: offset o sits on lane BYTES-1-o, field grows toward lane 0.
  always_comb begin
    lo = BYTES - int'(off3) - int'(size);
    shamt = (lo > 0) ? lo : 0;
    shifted = rdata >> (8 * shamt);
  end

  // Alignment check; 64-bit-only ops never fit a 32-bit datapath.
  always_comb begin
    misalign = 1'b0;
    case (size)
      4'd2:    misalign = off3[0];
      4'd4:    misalign = (off3[1:0] != 2'b00);
      4'd8:    misalign = (off3 != 3'b000);
      default: misalign = 1'b0;
    endcase
    if (BYTES == 4 && (op inside {OP_LWU, OP_LD, OP_SD}))
      misalign = 1'b1;
  end

  // Store strobes cover the lanes of the field; loads drive no strobes.
  always_comb begin
    strb = '0;
    if (op_is_store(op)) begin
      for (int i = 0; i < BYTES; i++) begin
        if (i >= lo && i < lo + int'(size))
          strb[i] = 1'b1;
      end
    end
  end

  // Store data replicated so the field appears on every lane group.
  always_comb begin
    case (size)
      4'd1:    wdata_rep = {BYTES{wdata[7:0]}};
      4'd2:    wdata_rep = {(BYTES/2){wdata[15:0]}};
      4'd4:    wdata_rep = {(BYTES/4){wdata[31:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // Load data: selected field right-justified, then sign- or zero-extended.
  always_comb begin
    case (size)
      4'd1:
        if (sgn) rdata_ext = DATA_WIDTH'($signed(shifted[7:0]));
        else     rdata_ext = DATA_WIDTH'(shifted[7:0]);
      4'd2:
        if (sgn) rdata_ext = DATA_WIDTH'($signed(shifted[15:0]));
        else     rdata_ext = DATA_WIDTH'(shifted[15:0]);
      4'd4:
        if (sgn) rdata_ext = DATA_WIDTH'($signed(shifted[31:0]));
        else     rdata_ext = DATA_WIDTH'(shifted[31:0]);
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - sequential load/store stage between exec and the data bus
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 3,
  parameter int PREG_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  mem_op_t                   in_op,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [DATA_WIDTH-1:0]     in_wdata,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  input  logic [PREG_WIDTH-1:0]     in_preg,
  input  logic                      in_wb_reg,
  output logic                      bus_req_valid,
  input  logic                      bus_req_ready,
  output logic                      bus_req_we,
  output logic [ADDR_WIDTH-1:0]     bus_req_addr,
  output logic [DATA_WIDTH-1:0]     bus_req_wdata,
  output logic [DATA_WIDTH/8-1:0]   bus_req_strb,
  input  logic                      bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     bus_rsp_rdata,
  output logic                      wb_valid,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [TAG_WIDTH-1:0]      wb_tag,
  output logic [PREG_WIDTH-1:0]     wb_preg,
  output logic                      wb_reg,
  output logic                      wb_exc,
  output logic                      wb_exc_store
);

  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int OFFW  = off_width(DATA_WIDTH);

  mau_state_t             state, state_nxt;
  mem_op_t                op_q, fmt_op;
  logic [OFFW-1:0]        off_q, fmt_off;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [PREG_WIDTH-1:0]  preg_q;
  logic                   wb_reg_q;
  logic [BYTES-1:0]       fmt_strb;
  logic [DATA_WIDTH-1:0]  fmt_wdata, fmt_rdata;
  logic                   fmt_misalign;
  logic                   accept, handshake;

  assign in_ready  = rst_n && (state == ST_IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign handshake = bus_req_valid && bus_req_ready;

  // The formatter looks at the incoming op while idle and at the held op otherwise.
  assign fmt_op  = (state == ST_IDLE) ? in_op : op_q;
  assign fmt_off = (state == ST_IDLE) ? in_addr[OFFW-1:0] : off_q;

  mem_lane_format #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
    .op        (fmt_op),
    .offset    (fmt_off),
    .wdata     (in_wdata),
    .rdata     (bus_rsp_rdata),
    .strb      (fmt_strb),
    .wdata_rep (fmt_wdata),
    .rdata_ext (fmt_rdata),
    .misalign  (fmt_misalign)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state; a response coincident with the request handshake is not consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (accept && op_size(in_op) != 4'd0 && !fmt_misalign) state_nxt = ST_REQ;
      ST_REQ:
        if (handshake)  state_nxt = flush ? ST_DRAIN : ST_WAIT;
        else if (flush) state_nxt = ST_IDLE;
      ST_WAIT:
        if (bus_rsp_valid) state_nxt = ST_IDLE;
        else if (flush)    state_nxt = ST_DRAIN;
      ST_DRAIN:
        if (bus_rsp_valid) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Op capture, registered bus request and one-cycle writeback pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= OP_NONE;
      off_q         <= '0;
      tag_q         <= '0;
      preg_q        <= '0;
      wb_reg_q      <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_req_we    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_strb  <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_tag        <= '0;
      wb_preg       <= '0;
      wb_reg        <= 1'b0;
      wb_exc        <= 1'b0;
      wb_exc_store  <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_tag       <= '0;
      wb_preg      <= '0;
      wb_reg       <= 1'b0;
      wb_exc       <= 1'b0;
      wb_exc_store <= 1'b0;

      if (handshake || (state == ST_REQ && flush))
        bus_req_valid <= 1'b0;

      if (accept) begin
        op_q     <= in_op;
        off_q    <= in_addr[OFFW-1:0];
        tag_q    <= in_tag;
        preg_q   <= in_preg;
        wb_reg_q <= in_wb_reg;
        if (op_size(in_op) == 4'd0) begin
          wb_valid <= 1'b1;
          wb_data  <= DATA_WIDTH'(in_addr);
          wb_tag   <= in_tag;
          wb_preg  <= in_preg;
          wb_reg   <= in_wb_reg;
        end else if (fmt_misalign) begin
          wb_valid     <= 1'b1;
          wb_tag       <= in_tag;
          wb_preg      <= in_preg;
          wb_exc       <= 1'b1;
          wb_exc_store <= op_is_store(in_op) ? EXC_ADES : EXC_ADEL;
        end else begin
          bus_req_valid <= 1'b1;
          bus_req_we    <= op_is_store(in_op);
          bus_req_addr  <= {in_addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
          bus_req_wdata <= op_is_store(in_op) ? fmt_wdata : '0;
          bus_req_strb  <= fmt_strb;
        end
      end

      if (state == ST_WAIT && bus_rsp_valid && !flush) begin
        wb_valid <= 1'b1;
        wb_tag   <= tag_q;
        wb_preg  <= preg_q;
        if (!op_is_store(op_q)) begin
          wb_data <= fmt_rdata;
          wb_reg  <= wb_reg_q;
        end
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised memory-access stage that replaces the combinational load/store formatting on the exec-to-memory boundary with a sequential unit. Accepts one exec-stage operation at a time. Issues a valid/ready request to the data bus, waits any number of cycles for the response, then formats load data for the big-endian datapath. Supports 32- or 64-bit datapaths, detects misalignment, and drains in-flight responses on flush.

Parameters:
DATA_WIDTH, 32, datapath width; 32 or 64 only.
ADDR_WIDTH, 32, byte address width.
TAG_WIDTH, 3, active-list index width carried with the op.
PREG_WIDTH, 6, physical destination register width.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  kill op in unit (local or global flush, OR'd upstream)
in_valid  in  1  exec stage presents an op
in_ready  out  1  unit can accept op this cycle
in_op  in  4  mem_op_t from shared package (NONE,LB,LBU,LH,LHU,LW,LWU,LD,SB,SH,SW,SD)
in_addr  in  ADDR_WIDTH  effective address / ALU result
in_wdata  in  DATA_WIDTH  store source register
in_tag  in  TAG_WIDTH  active-list index
in_preg  in  PREG_WIDTH  physical write address
in_wb_reg  in  1  op writes a register
bus_req_valid  out  1  data-bus request
bus_req_ready  in  1  bus accepts request
bus_req_we  out  1  1 = write
bus_req_addr  out  ADDR_WIDTH  address, aligned to DATA_WIDTH/8
bus_req_wdata  out  DATA_WIDTH  lane-replicated store data
bus_req_strb  out  DATA_WIDTH/8  byte strobes; bit [BYTES-1] = byte offset 0
bus_rsp_valid  in  1  response beat (one per request, reads and writes)
bus_rsp_rdata  in  DATA_WIDTH  raw read word
wb_valid  out  1  one-cycle result pulse
wb_data  out  DATA_WIDTH  formatted load data or pass-through ALU result
wb_tag  out  TAG_WIDTH  active-list index
wb_preg  out  PREG_WIDTH  physical write address
wb_reg  out  1  register-write enable
wb_exc  out  1  address error
wb_exc_store  out  1  1 = AdES, 0 = AdEL (valid with wb_exc)

Behaviour:
- Reset: all outputs 0; state IDLE; internal op registers cleared; in_ready=0 during reset, 1 after.
- States: IDLE, REQ, WAIT, DRAIN.
- in_ready=1 only in IDLE; an op is accepted when in_valid && in_ready && !flush.
- Non-memory op (NONE), accepted at cycle N: wb_valid=1 at N+1, wb_data=in_addr zero-extended, stays IDLE.
- Alignment rule: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
  - LWU/LD/SD with DATA_WIDTH=32 are treated as misaligned.
- Misaligned op at N: no bus request; wb_valid at N+1 with wb_exc=1, wb_exc_store set for stores, wb_reg=0.
- Aligned memory op at N: state REQ at N+1.
  - bus_req_* are registered and held stable until bus_req_ready.
  - On handshake go to WAIT; bus_rsp_valid in the same handshake cycle is ignored.
- WAIT, bus_rsp_valid at cycle K: wb_valid at K+1, then IDLE.
  - Stores: wb_data=0, wb_reg=0.
- Byte lanes are big-endian: offset o maps to bus byte lane BYTES-1-o.
- Load formatting:
  - LB/LH/LW: sign-extend the selected field to DATA_WIDTH.
  - LBU/LHU/LWU: zero-extend the selected field.
  - LD: full word.
- Store formatting:
  - SB: byte replicated BYTES times; SH and SW: field replicated across the word.
  - strb: 1 (byte), 2 (half) or 4 (word) ones starting at lane BYTES-1-o.
  - SD: all ones.
- Flush:
  - In REQ: drop request immediately (bus_req_valid=0 next cycle) if no handshake this cycle; otherwise go to DRAIN.
  - In WAIT: go to DRAIN.
  - DRAIN consumes one bus_rsp_valid with no wb_valid, then goes to IDLE.
  - In IDLE: suppresses the accept and any pending wb_valid for an op accepted the same cycle.
  - flush has no effect in DRAIN.
- Only one request is outstanding at any time; no request is issued in DRAIN.
- Reset mid-transaction: returns to IDLE immediately; an orphan bus response after reset is ignored in IDLE.

Decomposition:
- Shared package (defines): mem_op_t encoding, state encoding, EXC_ADEL/EXC_ADES codes, BYTES=DATA_WIDTH/8 and offset-width helper.
- One natural sub-module, mem_lane_format: purely combinational.
  - Inputs: op, offset, wdata, rdata.
  - Outputs: strb, replicated wdata, extended load data, misalign flag.
- Main module holds the FSM and registers.

Test Plan:
- Case 1 (32-bit): LB addr 0x1001, bus returns 0x11F2_3344 after 3 wait cycles -> bus_req_addr=0x1000, strb=0000, wb_data=0xFFFF_FFF2 one cycle after rsp.
- Case 2 (32-bit): SH addr 0x2002, wdata 0x0000_ABCD, ready same cycle as REQ -> wdata=0xABCD_ABCD, strb=0011, then wb_valid with wb_reg=0.
- Case 3 (64-bit): LWU addr 0x8, rdata 0x8000_0001_8765_4321 -> wb_data=0x0000_0000_8000_0001.
- Case 4: LW addr 0x3002 -> no bus_req_valid, wb_valid next cycle with wb_exc=1 and wb_exc_store=0. Same for SD on a 32-bit build, with wb_exc_store=1.
- Case 5: flush asserted while in WAIT -> no wb_valid; in_ready stays 0 until the response arrives 5 cycles later, then 1; the next op is processed normally.
- Case 6: asynchronous rst_n pulse while in REQ -> bus_req_valid=0 immediately, all wb outputs 0, state IDLE; a stray bus_rsp_valid afterwards produces no wb_valid.
